// File: rtl/addr_ch_select_seq.sv
// Address-to-(channel, register) decoder for a banked register file.
// Division by REGS_PER_CH is done by repeated subtraction, one step per cycle.
module addr_ch_select_seq #(
   parameter int ADDR_W      = 7,
   parameter int BASE_ADDR   = 11,
   parameter int NUM_CH      = 8,
   parameter int REGS_PER_CH = 7,
   parameter int SEL_W       = $clog2(REGS_PER_CH+1),
   parameter int CH_W        = $clog2(NUM_CH+1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cs,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr,
   input  logic              incr,
   output logic [SEL_W-1:0]  select_reg,
   output logic [CH_W-1:0]   select_ch,
   output logic              valid,
   output logic              busy,
   output logic              oor
);

   localparam logic [31:0]       LO_ADDR  = 32'(BASE_ADDR);
   localparam logic [31:0]       HI_ADDR  = 32'(BASE_ADDR + NUM_CH*REGS_PER_CH);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] REGS_A   = ADDR_W'(REGS_PER_CH);
   localparam logic [SEL_W-1:0]  LAST_REG = SEL_W'(REGS_PER_CH-1);
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH-1);

   typedef enum logic [1:0] {IDLE, DECODE, READY, OOR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [SEL_W-1:0]  sreg_q, sreg_d;
   logic [CH_W-1:0]   sch_q, sch_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              oor_q, oor_d;

   logic [31:0] addr_ext;
   logic        in_range;

   // Range check is done on a widened copy so the subtraction below never underflows.
   assign addr_ext = 32'(addr);
   assign in_range = (addr_ext >= LO_ADDR) && (addr_ext < HI_ADDR);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      ch_d    = ch_q;
      sreg_d  = sreg_q;
      sch_d   = sch_q;
      if (!cs) begin
         state_d = IDLE;
      end else if (addr_load) begin
         if (in_range) begin
            state_d = DECODE;
            rem_d   = addr - BASE_A;
            ch_d    = '0;
         end else begin
            state_d = OOR;
         end
      end else begin
         case (state_q)
            DECODE: begin
               if (rem_q >= REGS_A) begin
                  rem_d = rem_q - REGS_A;
                  ch_d  = ch_q + CH_W'(1);
               end else begin
                  state_d = READY;
                  sreg_d  = rem_q[SEL_W-1:0];
                  sch_d   = ch_q;
               end
            end
            READY: begin
               if (incr) begin
                  if (sreg_q != LAST_REG) begin
                     sreg_d = sreg_q + SEL_W'(1);
                  end else if (sch_q == LAST_CH) begin
                     state_d = OOR;
                  end else begin
                     sreg_d = '0;
                     sch_d  = sch_q + CH_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
      // Outputs are registered from the next state so they line up with it.
      if (state_d != READY) begin
         sreg_d = '1;
         sch_d  = '1;
      end
      valid_d = (state_d == READY);
      busy_d  = (state_d == DECODE);
      oor_d   = (state_d == OOR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         rem_q   <= '0;
         ch_q    <= '0;
         sreg_q  <= '1;
         sch_q   <= '1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         ch_q    <= ch_d;
         sreg_q  <= sreg_d;
         sch_q   <= sch_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         oor_q   <= oor_d;
      end
   end

   assign select_reg = sreg_q;
   assign select_ch  = sch_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign oor        = oor_q;

endmodule

// File: tb/tb_addr_ch_select_seq.sv
// Bench for addr_ch_select_seq: directed vector table, random run against an
// abstract position model, async reset sequence and a small-parameter sweep.
module tb_addr_ch_select_seq;

   localparam int B = 11, R = 7, N = 8;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cs, addr_load, incr;
   logic [6:0] addr;
   logic [2:0] sreg;
   logic [3:0] sch;
   logic       valid, busy, oor;

   logic       cs2, ld2, inc2;
   logic [6:0] addr2;
   logic [1:0] sreg2;
   logic [2:0] sch2;
   logic       valid2, busy2, oor2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   addr_ch_select_seq dut (
      .clk(clk), .rstn(rstn), .cs(cs), .addr_load(addr_load), .addr(addr), .incr(incr),
      .select_reg(sreg), .select_ch(sch), .valid(valid), .busy(busy), .oor(oor));

   addr_ch_select_seq #(.ADDR_W(7), .BASE_ADDR(0), .NUM_CH(4), .REGS_PER_CH(3)) dut2 (
      .clk(clk), .rstn(rstn), .cs(cs2), .addr_load(ld2), .addr(addr2), .incr(inc2),
      .select_reg(sreg2), .select_ch(sch2), .valid(valid2), .busy(busy2), .oor(oor2));

   typedef struct {
      bit         c, l, i;
      int         a;
      logic [9:0] exp;
   } vec_t;
   vec_t tbl[$];

   // Model: mode 0 idle, 1 decoding, 2 ready, 3 out of range. pos is the linear
   // offset from BASE; left counts decode cycles still owed before ready.
   int m_mode = 0, m_pos = 0, m_left = 0;

   function automatic logic [9:0] outs();
      return {valid, busy, oor, sreg, sch};
   endfunction

   function automatic logic [9:0] pk(bit v, bit b, bit o, int r, int ch);
      return {v, b, o, 3'(r), 4'(ch)};
   endfunction

   function automatic logic [9:0] model_exp();
      case (m_mode)
         1:       return pk(0, 1, 0, 7, 15);
         2:       return pk(1, 0, 0, m_pos % R, m_pos / R);
         3:       return pk(0, 0, 1, 7, 15);
         default: return pk(0, 0, 0, 7, 15);
      endcase
   endfunction

   task automatic model_step(input bit c, input bit l, input bit i, input int a);
      if (!c) m_mode = 0;
      else if (l) begin
         if (a >= B && a < B + N*R) begin
            m_mode = 1; m_pos = a - B; m_left = m_pos / R;
         end else m_mode = 3;
      end else if (m_mode == 1) begin
         if (m_left == 0) m_mode = 2;
         else m_left--;
      end else if (m_mode == 2 && i) begin
         m_pos++;
         if (m_pos >= N*R) m_mode = 3;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input bit c, input bit l, input bit i, input int a);
      cs = c; addr_load = l; incr = i; addr = 7'(a);
      @(posedge clk);
      model_step(c, l, i, a);
      #1;
   endtask

   task automatic add(input bit c, input bit l, input bit i, input int a,
                      input bit v, input bit b, input bit o, input int r, input int ch);
      vec_t t;
      t.c = c; t.l = l; t.i = i; t.a = a; t.exp = pk(v, b, o, r, ch);
      tbl.push_back(t);
   endtask

   initial begin
      rstn = 1'b0; cs = 0; addr_load = 0; incr = 0; addr = 0;
      cs2 = 0; ld2 = 0; inc2 = 0; addr2 = 0;

      // load 11: one busy cycle then ch0/reg0
      add(1,1,0,11, 0,1,0,7,15);  add(1,0,0,0, 1,0,0,0,0);
      // out of range on both sides; incr ignored in OOR
      add(1,1,0,10, 0,0,1,7,15);  add(1,0,1,0, 0,0,1,7,15);
      add(1,1,0,67, 0,0,1,7,15);
      // last reg of ch0, incr wraps into ch1
      add(1,1,0,17, 0,1,0,7,15);  add(1,0,0,0, 1,0,0,6,0);
      add(1,0,1,0,  1,0,0,0,1);
      // load beats incr; 25 -> ch2 reg0 on 4th edge
      add(1,1,1,25, 0,1,0,7,15);  add(1,0,0,0, 0,1,0,7,15);
      add(1,0,0,0,  0,1,0,7,15);  add(1,0,0,0, 1,0,0,0,2);
      add(1,0,1,0,  1,0,0,1,2);
      add(0,0,0,0,  0,0,0,7,15);  add(1,0,1,0, 0,0,0,7,15);
      // cs drop mid-decode, later incr and cs-low load ignored
      add(1,1,0,60, 0,1,0,7,15);  add(1,0,0,0, 0,1,0,7,15);
      add(0,0,0,0,  0,0,0,7,15);  add(1,0,1,0, 0,0,0,7,15);
      add(0,1,0,11, 0,0,0,7,15);
      // 66: eight busy cycles, ch7 reg6, then incr runs off the end
      add(1,1,0,66, 0,1,0,7,15);
      for (int k = 0; k < 7; k++) add(1,0,0,0, 0,1,0,7,15);
      add(1,0,0,0,  1,0,0,6,7);   add(1,0,1,0, 0,0,1,7,15);
      add(1,0,0,0,  0,0,1,7,15);
      // reload during decode restarts
      add(1,1,0,11, 0,1,0,7,15);  add(1,1,0,18, 0,1,0,7,15);
      add(1,0,0,0,  0,1,0,7,15);  add(1,0,0,0, 1,0,0,0,1);

      repeat (2) @(posedge clk);
      #1 chk("reset_outs", outs(), pk(0,0,0,7,15));
      chk("reset_outs2", {valid2, busy2, oor2, sreg2, sch2}, {3'b000, 2'h3, 3'h7});
      #2 rstn = 1'b1;

      foreach (tbl[n]) begin
         step(tbl[n].c, tbl[n].l, tbl[n].i, tbl[n].a);
         chk($sformatf("vec%0d", n), outs(), tbl[n].exp);
      end

      // async reset mid-decode, then load accepted on first edge after release
      step(1,1,0,66); step(1,0,0,0); step(1,0,0,0);
      chk("pre_rst_busy", outs(), pk(0,1,0,7,15));
      #2 rstn = 1'b0;
      #1 chk("rst_async", outs(), pk(0,0,0,7,15));
      m_mode = 0;
      @(posedge clk); #1 chk("rst_held", outs(), pk(0,0,0,7,15));
      #2 rstn = 1'b1;
      step(1,1,0,11); chk("rel_load", outs(), pk(0,1,0,7,15));
      step(1,0,0,0);  chk("rel_ready", outs(), pk(1,0,0,0,0));

      for (int n = 0; n < 400; n++) begin
         bit c, l, i;
         int a;
         c = ($urandom_range(0, 19) != 0);
         l = ($urandom_range(0, 5) == 0);
         i = ($urandom_range(0, 2) == 0);
         a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(5, 72));
         step(c, l, i, a);
         chk($sformatf("rand%0d", n), outs(), model_exp());
      end
      step(0,0,0,0);

      // small-parameter sweep: NUM_CH=4, REGS_PER_CH=3, BASE=0
      for (int a = 0; a < 128; a++) begin
         int edges;
         cs2 = 1; ld2 = 1; addr2 = 7'(a);
         @(posedge clk); #1;
         ld2 = 0; edges = 1;
         while (!valid2 && !oor2 && edges < 12) begin
            @(posedge clk); #1;
            edges++;
         end
         if (a < 12) begin
            chk($sformatf("sw%0d_sel", a), {valid2, busy2, oor2, sreg2, sch2},
                {3'b100, 2'(a % 3), 3'(a / 3)});
            chk($sformatf("sw%0d_lat", a), edges, a / 3 + 2);
         end else begin
            chk($sformatf("sw%0d_oor", a), {valid2, busy2, oor2, sreg2, sch2}, {3'b001, 2'h3, 3'h7});
            chk($sformatf("sw%0d_lat", a), edges, 1);
         end
         cs2 = 0;
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/addr_ch_select_seq.md
ADDR_CH_SELECT_SEQ -- requirements
Module: addr_ch_select_seq

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- ADDR_W, 7, address width.
- BASE_ADDR, 11, first channel-register address.
- NUM_CH, 8, number of channels.
- REGS_PER_CH, 7, registers per channel; REGS_PER_CH < 2**SEL_W.
- SEL_W, $clog2(REGS_PER_CH+1), select_reg width.
- CH_W, $clog2(NUM_CH+1), select_ch width.

REQ-002 The module SHALL have the following ports (name, direction, width, meaning). It SHALL use one clock. Reset SHALL be asynchronous and active-low.
- clk, in, 1, sole clock; rising edge.
- rstn, in, 1, asynchronous active-low reset.
- cs, in, 1, chip select; low aborts the current access.
- addr_load, in, 1, one-cycle pulse; sample addr.
- addr, in, ADDR_W, start address.
- incr, in, 1, one-cycle pulse; advance to the next register (burst read).
- select_reg, out, SEL_W, register index within the channel; all-ones when not valid.
- select_ch, out, CH_W, channel index; all-ones when not valid.
- valid, out, 1, select_reg and select_ch are decoded and in range.
- busy, out, 1, decode in progress.
- oor, out, 1, address is out of range.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The module SHALL have four states: IDLE, DECODE, READY and OOR.
REQ-005 The decode SHALL be select_ch = (addr-BASE_ADDR)/REGS_PER_CH and select_reg = (addr-BASE_ADDR)%REGS_PER_CH. It SHALL be computed by iterative subtraction with no divider.
REQ-006 addr_load with cs=1 in any state SHALL behave as follows:
- In range (BASE_ADDR <= addr < BASE_ADDR+NUM_CH*REGS_PER_CH): go to DECODE with rem = addr-BASE_ADDR and ch = 0.
- Otherwise: go to OOR.
REQ-007 DECODE, per cycle:
- If rem >= REGS_PER_CH: rem -= REGS_PER_CH and ch += 1.
- Else: go to READY with select_reg = rem, select_ch = ch and valid = 1.
REQ-008 Latency SHALL be valid high on the (k+2)th rising edge after the load edge, where k = final select_ch. The maximum latency is NUM_CH+1 cycles.
REQ-009 busy SHALL be 1 exactly while in DECODE. valid and oor SHALL be 0 in DECODE.
REQ-010 In READY, incr SHALL advance in one cycle:
- select_reg+1.
- At REGS_PER_CH-1: wrap select_reg to 0 and increment select_ch.
- At the last register of the last channel: go to OOR.
REQ-011 In OOR, the outputs SHALL be valid = 0, oor = 1, busy = 0, and select_reg and select_ch all-ones. The module SHALL stay in OOR until the next addr_load or cs low.
REQ-012 Boundary and priority rules:
- addr_load and incr in the same cycle: addr_load wins.
- addr_load during DECODE: restarts the decode with the new addr.
- incr in IDLE, DECODE or OOR: ignored.
- addr_load or incr while cs = 0: ignored.
REQ-013 cs = 0 sampled at any edge SHALL return the module to IDLE on that edge. IDLE outputs SHALL be valid = 0, busy = 0, oor = 0, and select_reg and select_ch all-ones.
REQ-014 Width arithmetic: rem SHALL be ADDR_W bits. The addr-BASE_ADDR subtraction SHALL be evaluated only after the range check, so negative values never occur.

Reset
REQ-015 rstn = 0 SHALL asynchronously force IDLE, with rem = 0, ch = 0, select_reg and select_ch all-ones, and valid, busy and oor = 0.
REQ-016 Release of rstn SHALL be synchronous to clk. The first addr_load SHALL be accepted on the first edge after release.
REQ-017 Reset during DECODE or READY SHALL discard the in-progress decode.

Verification (default parameters)
REQ-018 addr = 11 load -> busy for 1 cycle; on the 2nd edge valid = 1, select_ch = 0, select_reg = 0.
REQ-019 addr = 66 load -> busy for 8 cycles; on the 9th edge valid = 1, select_ch = 7, select_reg = 6. Then incr -> OOR: oor = 1, valid = 0, selects = all-ones.
REQ-020 addr = 10 load and addr = 67 load -> each gives oor = 1 on the 1st edge, busy = 0, selects all-ones.
REQ-021 addr = 17 (ch 0, reg 6) then incr -> select_ch = 1, select_reg = 0, valid = 1 after one edge. Simultaneous incr with addr_load(addr = 25) -> ch 2, reg 0 after 4 edges.
REQ-022 addr = 60 load, then cs = 0 on the 3rd cycle -> IDLE on that edge, busy = 0, valid = 0. A later incr has no effect.
REQ-023 rstn asserted mid-DECODE -> outputs immediately (before the next clk edge) take their REQ-015 reset values, with no glitch to valid = 1.
REQ-024 Parameter sweep (NUM_CH = 4, REGS_PER_CH = 3, BASE_ADDR = 0) -> exhaustive addr 0..127 matches the REQ-005 reference model.
